aes_enc_iter_ctrl: RTL and testbench
====================================

# aes_enc_iter_ctrl

Iterative AES-128 encryption controller. It time-multiplexes one instance of the existing combinational `round` module and one `roundlast` instance over the ten AES rounds, one round per clock. A valid/ready handshake on each side lets it sit between a block source (e.g. a UART/bus front end) and a ciphertext sink. It replaces the fully unrolled ten-round datapath where area matters more than throughput.

## Interface
- No parameters. AES-128 only; the round count is fixed at 10.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data`/`in_key` hold a block to encrypt.
- `in_ready` output 1: controller can accept a block this cycle.
- `in_data` input 128: plaintext, bit 127 = first byte MSB.
- `in_key` input 128: cipher key, same byte order.
- `out_valid` output 1: `out_data` holds a finished ciphertext.
- `out_ready` input 1: sink accepts `out_data` this cycle.
- `out_data` output 128: ciphertext, registered.
- `busy` output 1: high in RUN or LAST.

## Operation
- **Registers**
  - `st_reg` (128): round state.
  - `key_reg` (128): current round key.
  - `rc` (4): round index 0..9.
  - `out_reg` (128).
  - FSM: IDLE, RUN, LAST, DONE.
- **Datapath**
  - `round` is driven with (`rc`, `st_reg`, `key_reg`) and produces next state and next key.
  - `roundlast` is driven with (4'b1001, `st_reg`, `key_reg`).
- **`in_ready`** = (FSM == IDLE) or (FSM == DONE and `out_ready`).
- **Accept** (`in_valid` and `in_ready`):
  - `st_reg` <= `in_data` ^ `in_key`.
  - `key_reg` <= `in_key`.
  - `rc` <= 0.
  - FSM -> RUN.
- **RUN:** each cycle:
  - `st_reg` <= round state output.
  - `key_reg` <= round key output.
  - `rc` <= `rc` + 1.
  - When `rc` == 8 is consumed (the ninth round), FSM -> LAST and `rc` becomes 9.
- **LAST:**
  - `out_reg` <= `roundlast` output.
  - FSM -> DONE.
  - `st_reg`/`key_reg` do not care.
- **DONE:**
  - `out_valid` = 1.
  - `out_data` is held stable until `out_ready`.
  - On `out_ready` with no new accept, FSM -> IDLE.
  - On `out_ready` and a simultaneous accept, the new block is loaded and FSM -> RUN directly.
- **Input-side rules**
  - `in_valid` without `in_ready` is ignored. No buffering, and no effect on an in-flight block.
  - Input data/key changes after the accept cycle have no effect.
- **`rc` arithmetic:** 4-bit, never exceeds 9. Values 10..15 are unreachable; if forced, the FSM returns to IDLE.
- **Reset** (asynchronous, any state):
  - FSM = IDLE.
  - `rc` = 0.
  - `st_reg`, `key_reg`, `out_reg` = 0.
  - The in-flight block is discarded; there is no partial output.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data` = 0.
  - `busy` = 0.
- **Latency:** with the accept at rising edge E0, RUN occupies edges E1..E9 and LAST is edge E10. `out_valid` rises after E10, i.e. 10 cycles after the accept edge.
- **Throughput:** with `out_ready` held high, the accept at the DONE-exit edge gives back-to-back blocks every 11 cycles.
- **Combinational paths:**
  - `in_ready` depends combinationally on `out_ready`.
  - No other combinational input-to-output paths.
- **`busy` and `out_valid`:**
  - `busy` is high for exactly 10 cycles per block.
  - `out_valid` and `busy` are never high together.
- **Critical path:** one `round` evaluation (SubBytes/ShiftRows/MixColumns plus key expansion) per cycle.

## Test plan
- **Reset values:** assert `rst` -> `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0. Release `rst` and hold `in_valid`=0 for 20 cycles -> no change.
- **FIPS-197 Appendix C.1 vector:** `in_data`=00112233445566778899aabbccddeeff, `in_key`=000102030405060708090a0b0c0d0e0f, `out_ready`=1 -> `out_valid` rises 10 cycles after accept with `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a; `busy` is high for exactly 10 cycles.
- **Appendix B vector with backpressure:** `in_data`=3243f6a8885a308d313198a2e0370734, `in_key`=2b7e151628aed2a6abf7158809cf4f3c, `out_ready`=0 for 15 cycles after valid -> `out_data`=3925841d02dc09fbdc118597196a0b32 held stable and `in_ready`=0 throughout. Raise `out_ready` -> `out_valid` drops next cycle and `in_ready`=1.
- **Back-to-back blocks:** C.1 then B blocks with `in_valid` and `out_ready` held high -> second accept occurs on the DONE-exit cycle, results arrive 11 cycles apart, both correct.
- **Input changes while busy:** drive random `in_data`/`in_key` with `in_valid`=1 during RUN -> ignored; the first ciphertext is unchanged.
- **Reset mid-block:** assert `rst` at RUN with `rc`=5 -> all outputs return to reset values immediately. A fresh C.1 block after release -> correct ciphertext.

Source files
------------

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a shared
// round/roundlast datapath, valid/ready handshakes on both block interfaces.

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Multiplicative inverse as in^254 (maps 0 to 0), then the affine transform.
    always_comb begin
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, in_i);
        end
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_keyexp (
    input  logic [3:0]   rc_i,
    input  logic [127:0] key_i,
    output logic [127:0] key_o
);
    logic [7:0]  rcon;
    logic [31:0] rotWord;
    logic [31:0] subWord;
    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        case (rc_i)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rotWord = {key_i[23:0], key_i[31:24]};

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : gSub
            aes_sbox sboxInst (.in_i(rotWord[8*b +: 8]), .out_o(subWord[8*b +: 8]));
        end
    endgenerate

    assign w0    = key_i[127:96] ^ subWord ^ {rcon, 24'h0};
    assign w1    = key_i[95:64] ^ w0;
    assign w2    = key_i[63:32] ^ w1;
    assign w3    = key_i[31:0] ^ w2;
    assign key_o = {w0, w1, w2, w3};
endmodule

module round (
    input  logic [3:0]   rc_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [127:0] subBytes;
    logic [127:0] shifted;
    logic [127:0] mixed;

    aes_keyexp keyInst (.rc_i(rc_i), .key_i(key_i), .key_o(key_o));

    // Byte n sits at row n%4, column n/4; bit 127 is the MSB of byte 0.
    genvar n, r, c;
    generate
        for (n = 0; n < 16; n++) begin : gSub
            aes_sbox sboxInst (.in_i(state_i[127-8*n -: 8]), .out_o(subBytes[127-8*n -: 8]));
        end
        for (r = 0; r < 4; r++) begin : gRow
            for (c = 0; c < 4; c++) begin : gCol
                assign shifted[127-8*(r+4*c) -: 8] = subBytes[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (c = 0; c < 4; c++) begin : gMix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shifted[127-32*c -: 8];
            assign a1 = shifted[119-32*c -: 8];
            assign a2 = shifted[111-32*c -: 8];
            assign a3 = shifted[103-32*c -: 8];
            assign mixed[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mixed[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mixed[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mixed[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    assign state_o = mixed ^ key_o;
endmodule

module roundlast (
    input  logic [3:0]   rc_i,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);
    logic [127:0] subBytes;
    logic [127:0] shifted;
    logic [127:0] lastKey;

    aes_keyexp keyInst (.rc_i(rc_i), .key_i(key_i), .key_o(lastKey));

    genvar n, r, c;
    generate
        for (n = 0; n < 16; n++) begin : gSub
            aes_sbox sboxInst (.in_i(state_i[127-8*n -: 8]), .out_o(subBytes[127-8*n -: 8]));
        end
        for (r = 0; r < 4; r++) begin : gRow
            for (c = 0; c < 4; c++) begin : gCol
                assign shifted[127-8*(r+4*c) -: 8] = subBytes[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    endgenerate

    assign state_o = shifted ^ lastKey;
endmodule

module aes_enc_iter_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic [127:0] in_key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] out_q, out_d;
    logic [127:0] roundState, roundKey, lastState;
    logic         accept;

    round roundInst (
        .rc_i(rc_q), .state_i(st_q), .key_i(key_q),
        .state_o(roundState), .key_o(roundKey)
    );

    roundlast lastInst (
        .rc_i(4'b1001), .state_i(st_q), .key_i(key_q), .state_o(lastState)
    );

    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN) || (state_q == LAST);
    assign out_data_o  = out_q;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rc_d    = rc_q;
        out_d   = out_q;
        case (state_q)
            RUN: begin
                st_d  = roundState;
                key_d = roundKey;
                rc_d  = rc_q + 4'd1;
                if (rc_q == 4'd8) state_d = LAST;
            end
            LAST: begin
                out_d   = lastState;
                state_d = DONE;
            end
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new block can be taken from IDLE or on the DONE-exit cycle.
        if (accept) begin
            st_d    = in_data_i ^ in_key_i;
            key_d   = in_key_i;
            rc_d    = '0;
            state_d = RUN;
        end
        if (rc_q > 4'd9) begin
            state_d = IDLE;
            rc_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Self-checking bench for aes_enc_iter_ctrl: FIPS-197 vectors, handshake timing,
// and random blocks compared against a software AES-128 model.

module tb_aes_enc_iter_ctrl;
    logic         clk;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [127:0] inData;
    logic [127:0] inKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;
    logic         busy;

    int passCount  = 0;
    int totalCount = 0;

    logic [7:0] sboxTab [256];

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_enc_iter_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .in_data_i(inData), .in_key_i(inKey),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .out_data_o(outData), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from a brute-force search for each inverse, then the affine map bit by bit.
    task automatic buildSbox();
        logic [7:0] xb, yb, inv, o, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sboxTab[x] = o;
        end
    endtask

    function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        logic [7:0]  coef [4];
        logic [7:0]  acc;
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sboxTab[tmp[23:16]], sboxTab[tmp[15:8]], sboxTab[tmp[7:0]], sboxTab[tmp[31:24]]}
                      ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ key[127-8*n -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) s[n] = sboxTab[s[n]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd == 10) acc = t[r+4*c];
                    else begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-r+4)%4], t[k+4*c]);
                    end
                    s[r+4*c] = acc;
                end
            for (int n = 0; n < 16; n++) begin
                tmp  = w[4*rnd + n/4];
                s[n] = s[n] ^ tmp[31-8*(n%4) -: 8];
            end
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 128'(inReady), 128'd1);
        checkOutput({tag, "_out_valid"}, 128'(outValid), 128'd0);
        checkOutput({tag, "_out_data"}, outData, 128'd0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
    endtask

    // Presents a block at a falling edge; returns one falling edge after the accept edge.
    task automatic applyStimulus(input string tag, input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        inValid = 1'b1;
        inData  = d;
        inKey   = k;
        #1;
        checkOutput({tag, "_in_ready_at_accept"}, 128'(inReady), 128'd1);
        @(negedge clk);
        inValid = 1'b0;
        inData  = rand128();
        inKey   = rand128();
    endtask

    task automatic waitResult(input string tag, input logic [127:0] expData, input int expLat);
        int cycles  = 0;
        int busyCnt = 0;
        while (outValid !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busyCnt++;
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 128'(cycles), 128'(expLat));
        checkOutput({tag, "_busy_cycles"}, 128'(busyCnt), 128'(expLat));
        checkOutput({tag, "_out_valid"}, 128'(outValid), 128'd1);
        checkOutput({tag, "_busy_with_valid"}, 128'(busy), 128'd0);
        checkOutput({tag, "_out_data"}, outData, expData);
    endtask

    initial begin
        logic [127:0] d, k, expCt;
        int gap, garbage, stall;

        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        inKey    = '0;
        outReady = 1'b0;
        buildSbox();
        #2;
        checkResetValues("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_in_ready", 128'(inReady), 128'd1);
            checkOutput("idle_out_valid", 128'(outValid), 128'd0);
            checkOutput("idle_busy", 128'(busy), 128'd0);
        end
        checkOutput("idle_out_data", outData, 128'd0);

        $display("[TB] FIPS-197 C.1 vector");
        outReady = 1'b1;
        applyStimulus("c1", C1_PT, C1_KEY);
        waitResult("c1", C1_CT, 10);
        @(negedge clk);
        checkOutput("c1_out_valid_drop", 128'(outValid), 128'd0);
        checkOutput("c1_in_ready_after", 128'(inReady), 128'd1);

        $display("[TB] Appendix B vector with backpressure");
        outReady = 1'b0;
        applyStimulus("bp", B_PT, B_KEY);
        waitResult("bp", B_CT, 10);
        for (int i = 0; i < 15; i++) begin
            inValid = 1'b1;
            inData  = rand128();
            inKey   = rand128();
            @(negedge clk);
            checkOutput("bp_hold_data", outData, B_CT);
            checkOutput("bp_hold_in_ready", 128'(inReady), 128'd0);
            checkOutput("bp_hold_out_valid", 128'(outValid), 128'd1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("bp_in_ready_comb", 128'(inReady), 128'd1);
        @(negedge clk);
        checkOutput("bp_out_valid_drop", 128'(outValid), 128'd0);
        checkOutput("bp_in_ready_idle", 128'(inReady), 128'd1);
        checkOutput("bp_busy_idle", 128'(busy), 128'd0);

        $display("[TB] back-to-back blocks");
        @(negedge clk);
        inValid = 1'b1;
        inData  = C1_PT;
        inKey   = C1_KEY;
        @(negedge clk);
        inData  = B_PT;
        inKey   = B_KEY;
        waitResult("b2b_first", C1_CT, 10);
        checkOutput("b2b_in_ready_done", 128'(inReady), 128'd1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) begin
                inValid = 1'b0;
                checkOutput("b2b_second_busy", 128'(busy), 128'd1);
            end
        end while (outValid !== 1'b1 && gap < 40);
        checkOutput("b2b_gap", 128'(gap), 128'd11);
        checkOutput("b2b_second_data", outData, B_CT);
        @(negedge clk);
        checkOutput("b2b_drain", 128'(outValid), 128'd0);

        $display("[TB] random blocks with inputs changing while busy");
        for (int blk = 0; blk < 4; blk++) begin
            d        = rand128();
            k        = rand128();
            expCt    = aesRef(d, k);
            garbage  = $urandom_range(1, 6);
            stall    = $urandom_range(0, 3);
            outReady = 1'b0;
            applyStimulus("rnd", d, k);
            for (int g = 0; g < garbage; g++) begin
                inValid = 1'b1;
                inData  = rand128();
                inKey   = rand128();
                @(negedge clk);
            end
            inValid = 1'b0;
            waitResult("rnd", expCt, 10 - garbage);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                checkOutput("rnd_stall_data", outData, expCt);
            end
            outReady = 1'b1;
            @(negedge clk);
            checkOutput("rnd_out_valid_drop", 128'(outValid), 128'd0);
        end

        $display("[TB] reset in the middle of a block");
        outReady = 1'b1;
        applyStimulus("mid", C1_PT, C1_KEY);
        repeat (5) @(negedge clk);
        checkOutput("mid_busy_before_reset", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        checkResetValues("mid_reset");
        @(negedge clk);
        checkResetValues("mid_reset_held");
        rst = 1'b0;
        applyStimulus("after_reset", C1_PT, C1_KEY);
        waitResult("after_reset", C1_CT, 10);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
